// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK_CPU,
        ACK_HOST
    } arb_state_t;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_HOST = 1'b1;

    localparam int unsigned DEF_AW          = 10;
    localparam int unsigned DEF_DW          = 32;
    localparam int unsigned DEF_MAX_CPU_RUN = 4;

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant decision for the D_Mem arbiter: CPU priority, host forced through once the
// starvation counter reaches MAX_CPU_RUN.
module dmem_arb_grant
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_CPU_RUN = DEF_MAX_CPU_RUN
) (
    input  logic clk1,
    input  logic rst,
    input  logic i_eval,
    input  logic i_cpu_req,
    input  logic i_host_req,
    output logic o_gnt_valid,
    output logic o_gnt_sel
);

    localparam logic [3:0] CntMax = 4'(MAX_CPU_RUN);

    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_cnt;
    logic       w_host_due;

    always_comb begin
        w_host_due  = i_host_req && (r_starve_cnt == CntMax);
        o_gnt_valid = i_cpu_req || i_host_req;
        if (w_host_due || !i_cpu_req) begin
            o_gnt_sel = GNT_HOST;
        end else begin
            o_gnt_sel = GNT_CPU;
        end
    end

    // Counter only moves on IDLE cycles; ack cycles leave it untouched.
    always_comb begin
        w_starve_cnt = r_starve_cnt;
        if (i_eval) begin
            if (!i_host_req || (o_gnt_sel == GNT_HOST)) begin
                w_starve_cnt = 4'd0;
            end else if (r_starve_cnt < CntMax) begin
                w_starve_cnt = r_starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_starve_cnt;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single synchronous D_Mem port between the CPU MEM stage and a host loader.
// Optional macro DMEM_RANGE_CHK_EN: accesses at or above MEM_DEPTH are dropped and acked with err.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned MAX_CPU_RUN = DEF_MAX_CPU_RUN
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    if (64'(MEM_DEPTH) > (64'd1 << AW)) begin : g_depth_chk
        $error("MEM_DEPTH exceeds the address space");
    end

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic          r_acc_we;
    logic          r_acc_err;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_host_rdata;

    logic          w_idle;
    logic          w_gnt_valid;
    logic          w_gnt_sel;
    logic          w_issue;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_range_err;
    logic          w_rd_upd;
    logic [DW-1:0] w_rd_data;

    assign w_idle  = (r_state == IDLE);
    assign w_issue = w_idle && w_gnt_valid;

    dmem_arb_grant #(
        .MAX_CPU_RUN (MAX_CPU_RUN)
    ) u_grant (
        .clk1        (clk1),
        .rst         (rst),
        .i_eval      (w_idle),
        .i_cpu_req   (cpu_req),
        .i_host_req  (host_req),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_sel   (w_gnt_sel)
    );

    always_comb begin
        if (w_gnt_sel == GNT_HOST) begin
            w_sel_we    = host_we;
            w_sel_addr  = host_addr;
            w_sel_wdata = host_wdata;
        end else begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
        end
    end

`ifdef DMEM_RANGE_CHK_EN
    assign w_range_err = (32'(w_sel_addr) >= MEM_DEPTH);
`else
    assign w_range_err = 1'b0;
`endif

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        unique case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_nxt = (w_gnt_sel == GNT_HOST) ? ACK_HOST : ACK_CPU;
                end
            end
            ACK_CPU:  w_state_nxt = IDLE;
            ACK_HOST: w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Direction and range status of the issued access, needed in its ack cycle.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_acc_we  <= 1'b0;
            r_acc_err <= 1'b0;
        end else if (w_issue) begin
            r_acc_we  <= w_sel_we;
            r_acc_err <= w_range_err;
        end
    end

    assign w_rd_upd  = !r_acc_we || r_acc_err;
    assign w_rd_data = r_acc_err ? '0 : mem_rdata;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            if ((r_state == ACK_CPU) && w_rd_upd) begin
                r_cpu_rdata <= w_rd_data;
            end
            if ((r_state == ACK_HOST) && w_rd_upd) begin
                r_host_rdata <= w_rd_data;
            end
        end
    end

    always_comb begin
        cpu_ack    = (r_state == ACK_CPU);
        host_ack   = (r_state == ACK_HOST);
        err        = (cpu_ack || host_ack) && r_acc_err;
        mem_en     = w_issue && !w_range_err && !rst;
        mem_we     = mem_en && w_sel_we;
        mem_addr   = w_sel_addr;
        mem_wdata  = w_sel_wdata;
        cpu_rdata  = (cpu_ack && w_rd_upd) ? w_rd_data : r_cpu_rdata;
        host_rdata = (host_ack && w_rd_upd) ? w_rd_data : r_host_rdata;
    end

    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous memory on the D_Mem port.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 512;

`ifdef DMEM_RANGE_CHK_EN
    localparam logic          EXP_OOB_EN  = 1'b0;
    localparam logic          EXP_OOB_ERR = 1'b1;
    localparam logic [DW-1:0] EXP_OOB_RD  = 32'h0;
`else
    localparam logic          EXP_OOB_EN  = 1'b1;
    localparam logic          EXP_OOB_ERR = 1'b0;
    localparam logic [DW-1:0] EXP_OOB_RD  = 32'hA5A5_0600;
`endif

    logic          clk1;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          host_req, host_we, host_ack;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          err, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:1023];

    int n_cmp;
    int n_bad;
    int stall_cnt;

    dmem_port_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .MEM_DEPTH   (DEPTH),
        .MAX_CPU_RUN (4)
    ) dut (
        .clk1       (clk1),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .err        (err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Memory contents are not cleared by rst; only the out-of-range marker word is seeded.
    always @(posedge clk1) begin
        if (rst) begin
            mem[600] <= 32'hA5A5_0600;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial stall_cnt = 0;
    always @(negedge clk1) if (cpu_stall) stall_cnt = stall_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One access by a single requester; lat counts sample points up to and including the ack.
    task automatic do_access(input logic host, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output int lat,
                             output logic [DW-1:0] rdata, output logic err_o,
                             output logic issue_en);
        bit done;
        lat = 0; rdata = '0; err_o = 1'b0; issue_en = 1'b0; done = 1'b0;
        if (host) begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int c = 1; c <= 10 && !done; c++) begin
            @(negedge clk1);
            if (c == 1) issue_en = mem_en;
            if (host ? host_ack : cpu_ack) begin
                lat   = c;
                rdata = host ? host_rdata : cpu_rdata;
                err_o = err;
                done  = 1'b1;
            end
        end
        @(posedge clk1); #1;
        if (host) host_req = 1'b0;
        else      cpu_req  = 1'b0;
    endtask

    int          pr_cpu_first, pr_host_first, pr_cpu_before_host, pr_cpu_seen, pr_host_seen;
    logic [31:0] pr_cpu_rdata, pr_host_rdata;

    // Both requesters raised together; the CPU walks upward through addresses between acks.
    task automatic run_pair(input int cpu_n, input int host_n);
        int  cs, hs;
        bit  ca, ha;
        cs = 0; hs = 0;
        pr_cpu_first = 0; pr_host_first = 0; pr_cpu_before_host = -1;
        pr_cpu_rdata = '0; pr_host_rdata = '0;
        cpu_req  = (cpu_n > 0);
        host_req = (host_n > 0);
        for (int c = 1; c <= 40 && (cs < cpu_n || hs < host_n); c++) begin
            @(negedge clk1);
            ca = cpu_ack;
            ha = host_ack;
            if (ca) begin
                cs++;
                if (cs == 1) pr_cpu_first = c;
                pr_cpu_rdata = cpu_rdata;
            end
            if (ha) begin
                hs++;
                if (hs == 1) begin
                    pr_host_first      = c;
                    pr_cpu_before_host = cs;
                end
                pr_host_rdata = host_rdata;
            end
            @(posedge clk1); #1;
            if (ca) begin
                if (cs < cpu_n) cpu_addr = cpu_addr + 1'b1;
                else            cpu_req  = 1'b0;
            end
            if (ha && hs >= host_n) host_req = 1'b0;
        end
        pr_cpu_seen  = cs;
        pr_host_seen = hs;
        cpu_req  = 1'b0;
        host_req = 1'b0;
    endtask

    initial begin
        int          lat, s0;
        logic [31:0] rd;
        logic        e, en;

        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) @(negedge clk1);
        check_eq("rst_ctrl", 32'({cpu_ack, host_ack, err, mem_en, mem_we}), 32'h0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
        check_eq("rst_host_rdata", host_rdata, 32'h0);
        check_eq("rst_state", 32'(dut.r_state), 32'(IDLE));
        check_eq("rst_starve", 32'(dut.u_grant.r_starve_cnt), 32'h0);
        @(posedge clk1); #1;
        rst = 1'b0;

        // Host preload and readback, CPU idle.
        s0 = stall_cnt;
        do_access(1'b1, 1'b1, 10'd200, 32'h4, lat, rd, e, en);
        check_eq("hwr_lat", 32'(lat), 32'd2);
        check_eq("hwr_en", 32'(en), 32'd1);
        check_eq("hwr_err", 32'(e), 32'd0);
        do_access(1'b1, 1'b0, 10'd200, 32'h0, lat, rd, e, en);
        check_eq("hrd_lat", 32'(lat), 32'd2);
        check_eq("hrd_data", rd, 32'h4);
        do_access(1'b1, 1'b1, 10'd198, 32'h11, lat, rd, e, en);
        check_eq("hpre_stall", 32'(stall_cnt - s0), 32'd0);

        // Simultaneous requests in IDLE: CPU first.
        cpu_we = 1'b0; cpu_addr = 10'd198;
        host_we = 1'b0; host_addr = 10'd200;
        s0 = stall_cnt;
        run_pair(1, 1);
        check_eq("cont_cpu_cyc", 32'(pr_cpu_first), 32'd2);
        check_eq("cont_host_cyc", 32'(pr_host_first), 32'd4);
        check_eq("cont_cpu_rd", pr_cpu_rdata, 32'h11);
        check_eq("cont_host_rd", pr_host_rdata, 32'h4);
        check_eq("cont_stall", 32'(stall_cnt - s0), 32'd1);

        // Starvation bound: four CPU grants, then the host, then the CPU again.
        cpu_we = 1'b0; cpu_addr = 10'd198;
        host_we = 1'b0; host_addr = 10'd200;
        run_pair(6, 1);
        check_eq("starve_cpu_pre", 32'(pr_cpu_before_host), 32'd4);
        check_eq("starve_host_cyc", 32'(pr_host_first), 32'd10);
        check_eq("starve_cpu_tot", 32'(pr_cpu_seen), 32'd6);
        check_eq("starve_host_tot", 32'(pr_host_seen), 32'd1);
        check_eq("starve_cnt_end", 32'(dut.u_grant.r_starve_cnt), 32'h0);

        // CPU store and host load of the same word in the same cycle.
        do_access(1'b0, 1'b0, 10'd200, 32'h0, lat, rd, e, en);
        check_eq("cld_data", rd, 32'h4);
        cpu_we = 1'b1; cpu_addr = 10'd198; cpu_wdata = 32'd24;
        host_we = 1'b0; host_addr = 10'd198;
        run_pair(1, 1);
        check_eq("wr_rd_cpu_cyc", 32'(pr_cpu_first), 32'd2);
        check_eq("wr_rd_host", pr_host_rdata, 32'd24);
        check_eq("wr_keep_cpu_rd", pr_cpu_rdata, 32'h4);

        // Reset in the ack cycle of a CPU store: write persists, ack is suppressed.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd210; cpu_wdata = 32'd33;
        @(negedge clk1);
        check_eq("rstw_issue_we", 32'(mem_we), 32'd1);
        @(posedge clk1); #2;
        rst = 1'b1;
        @(negedge clk1);
        check_eq("rstw_ack", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk1); #1;
        rst = 1'b0;

        // Reset in the ack cycle of a CPU load.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd200;
        @(negedge clk1);
        @(posedge clk1); #2;
        rst = 1'b1;
        @(negedge clk1);
        check_eq("rstr_ack", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk1); #1;
        rst = 1'b0;
        @(negedge clk1);
        check_eq("rstr_ctrl", 32'({cpu_ack, host_ack, err, mem_en, mem_we, cpu_stall}), 32'h0);
        check_eq("rstr_cpu_rd", cpu_rdata, 32'h0);
        check_eq("rstr_host_rd", host_rdata, 32'h0);
        @(posedge clk1); #1;
        do_access(1'b1, 1'b0, 10'd210, 32'h0, lat, rd, e, en);
        check_eq("rstw_persist", rd, 32'd33);
        do_access(1'b0, 1'b0, 10'd200, 32'h0, lat, rd, e, en);
        check_eq("post_rst_lat", 32'(lat), 32'd2);
        check_eq("post_rst_rd", rd, 32'h4);

        // Address beyond MEM_DEPTH.
        do_access(1'b0, 1'b0, 10'd600, 32'h0, lat, rd, e, en);
        check_eq("oob_lat", 32'(lat), 32'd2);
        check_eq("oob_mem_en", 32'(en), 32'(EXP_OOB_EN));
        check_eq("oob_err", 32'(e), 32'(EXP_OOB_ERR));
        check_eq("oob_rdata", rd, EXP_OOB_RD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not finish");
    end

endmodule
